z80_bus_responder: RTL and testbench

- Bus-side target for the Z80 control/datapath: memory and I/O responder on the other end of the CPU bus.
- Decodes the CPU strobes (M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L).
- Serves opcode fetches and memory reads from an internal byte RAM, commits memory writes, and forwards I/O and interrupt-acknowledge cycles.
- Inserts programmable wait states through WAIT_L. Used as the memory model in the top-level bench and as the on-chip RAM target.

---
 rtl/z80_bus_responder.sv | 215 +++++++++++++++++++++
 tb/tb_z80_bus_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_bus_responder.sv
// z80_bus_responder: memory / I/O target on the far side of the Z80 CPU bus.
// Decodes the CPU strobes, serves opcode fetches and memory reads from an internal byte RAM,
// commits memory writes, forwards I/O and interrupt-acknowledge cycles, and stretches each
// access with programmable wait states on WAIT_L.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   addr, data_in       CPU address and write data
//   data_out, data_oe   read data and bus-drive enable toward the CPU
//   M1_L .. RFSH_L      CPU strobes, active-low
//   WAIT_L              wait request to the CPU, active-low
//   io_rd_data          data returned by the I/O side on an I/O read
//   io_wr, io_rd        single-cycle I/O write commit / read-sample pulses
//   io_addr, io_wdata   latched I/O port number and write data
//   int_vector          byte returned on interrupt acknowledge
//   load_en/addr/data   RAM preload port, honoured only while idle
//   bus_err             sticky flag for illegal strobe combinations
module z80_bus_responder #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       addr,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              data_oe,
  input  logic              M1_L,
  input  logic              MREQ_L,
  input  logic              IORQ_L,
  input  logic              RD_L,
  input  logic              WR_L,
  input  logic              RFSH_L,
  output logic              WAIT_L,
  input  logic [7:0]        io_rd_data,
  output logic              io_wr,
  output logic              io_rd,
  output logic [7:0]        io_addr,
  output logic [7:0]        io_wdata,
  input  logic [7:0]        int_vector,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              bus_err
);

  localparam int unsigned Depth      = 2 ** ADDR_W;
  localparam logic [3:0]  MemWaitCnt = 4'(MEM_WAIT);
  localparam logic [3:0]  IoWaitCnt  = 4'(IO_WAIT);

  typedef enum logic [1:0] {StIdle, StWait, StAct, StHold} state_e;
  typedef enum logic [2:0] {CycMrd, CycMwr, CycIord, CycIowr, CycInta} cyc_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  cyc_e              cyc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic [7:0]        io_addr_q;
  logic [7:0]        io_wdata_q;
  logic              err_q;

  logic [7:0] mem [Depth];

  // Upper address bits are ignored so the RAM aliases across the 64 KiB space.
  logic unused_addr;
  assign unused_addr = ^addr[15:ADDR_W];

  // Strobe decode
  logic       dec_valid;
  logic       dec_err;
  cyc_e       dec_cyc;
  logic [3:0] dec_wait;
  logic       all_idle;

  assign all_idle = MREQ_L & IORQ_L & RD_L & WR_L;

  always_comb begin
    dec_valid = 1'b0;
    dec_err   = 1'b0;
    dec_cyc   = CycMrd;
    // Refresh cycles carry MREQ_L low but are never answered.
    if (RFSH_L) begin
      if ((!RD_L && !WR_L) || (!MREQ_L && !IORQ_L)) begin
        dec_err = 1'b1;
      end else if (!MREQ_L && !RD_L) begin
        dec_valid = 1'b1;
        dec_cyc   = CycMrd;
      end else if (!MREQ_L && !WR_L) begin
        dec_valid = 1'b1;
        dec_cyc   = CycMwr;
      end else if (!IORQ_L && !M1_L) begin
        dec_valid = 1'b1;
        dec_cyc   = CycInta;
      end else if (!IORQ_L && !RD_L) begin
        dec_valid = 1'b1;
        dec_cyc   = CycIord;
      end else if (!IORQ_L && !WR_L) begin
        dec_valid = 1'b1;
        dec_cyc   = CycIowr;
      end
    end
  end

  assign dec_wait = (dec_cyc == CycMrd || dec_cyc == CycMwr) ? MemWaitCnt : IoWaitCnt;

  // FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dec_valid) begin
          if (dec_wait != 4'd0) begin
            state_d = StWait;
            cnt_d   = dec_wait;
          end else begin
            state_d = StAct;
          end
        end
      end
      StWait: begin
        // CPU dropping every strobe mid-wait aborts the cycle with no side effect.
        if (all_idle) begin
          state_d = StIdle;
        end else if (cnt_q <= 4'd1) begin
          state_d = StAct;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAct:   state_d = StHold;
      StHold:  if (all_idle) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read path
  logic       is_read;
  logic [7:0] rd_value;

  assign is_read = (cyc_q == CycMrd) || (cyc_q == CycIord) || (cyc_q == CycInta);

  always_comb begin
    rd_value = 8'h00;
    case (cyc_q)
      CycMrd:  rd_value = mem[addr_q];
      CycIord: rd_value = io_rd_data;
      CycInta: rd_value = int_vector;
      default: rd_value = 8'h00;
    endcase
  end

  // Cycle attributes and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= CycMrd;
      addr_q     <= '0;
      data_q     <= 8'h00;
      io_addr_q  <= 8'h00;
      io_wdata_q <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      if (state_q == StIdle) begin
        if (dec_err) begin
          err_q <= 1'b1;
        end
        if (dec_valid) begin
          cyc_q     <= dec_cyc;
          addr_q    <= addr[ADDR_W-1:0];
          io_addr_q <= addr[7:0];
        end
      end
      // Freeze the read value so HOLD keeps driving it even if the source moves.
      if (state_q == StAct && is_read) begin
        data_q <= rd_value;
      end
      if (state_q == StAct && cyc_q == CycIowr) begin
        io_wdata_q <= data_in;
      end
    end
  end

  // RAM contents survive reset; reset only blocks a write pending on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StIdle && load_en) begin
        mem[load_addr] <= load_data;
      end else if (state_q == StAct && cyc_q == CycMwr) begin
        mem[addr_q] <= data_in;
      end
    end
  end

  assign data_out = (state_q == StAct) ? rd_value : data_q;
  assign data_oe  = is_read && (state_q == StAct || state_q == StHold);
  assign WAIT_L   = (state_q != StWait);
  assign io_wr    = (state_q == StAct) && (cyc_q == CycIowr);
  assign io_rd    = (state_q == StAct) && (cyc_q == CycIord);
  assign io_addr  = io_addr_q;
  assign io_wdata = io_wdata_q;
  assign bus_err  = err_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Scoreboard bench for z80_bus_responder. Two instances share one bus: one with zero memory
// wait states, one with two memory and three I/O wait states. Each bus cycle pushes one
// expected record per instance; a monitor collects what each instance did over the cycle
// and compares when the strobes release.
module tb_z80_bus_responder;

  localparam int KMrd = 0, KMwr = 1, KIord = 2, KIowr = 3, KInta = 4, KRfsh = 5, KIll = 6;

  function automatic int memw(input int d);
    return (d != 0) ? 2 : 0;
  endfunction

  function automatic int iow(input int d);
    return (d != 0) ? 3 : 1;
  endfunction

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        M1_L, MREQ_L, IORQ_L, RD_L, WR_L, RFSH_L;
  logic [7:0]  io_rd_data;
  logic [7:0]  int_vector;
  logic        load_en;
  logic [11:0] load_addr;
  logic [7:0]  load_data;

  logic [1:0][7:0] dout;
  logic [1:0]      oe;
  logic [1:0]      waitl;
  logic [1:0]      iowr;
  logic [1:0]      iord;
  logic [1:0][7:0] ioaddr;
  logic [1:0][7:0] iowdata;
  logic [1:0]      err;

  always #5 clk = ~clk;

  z80_bus_responder #(.ADDR_W(12), .MEM_WAIT(0), .IO_WAIT(1)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(dout[0]),
    .data_oe(oe[0]), .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L),
    .WR_L(WR_L), .RFSH_L(RFSH_L), .WAIT_L(waitl[0]), .io_rd_data(io_rd_data),
    .io_wr(iowr[0]), .io_rd(iord[0]), .io_addr(ioaddr[0]), .io_wdata(iowdata[0]),
    .int_vector(int_vector), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .bus_err(err[0])
  );

  z80_bus_responder #(.ADDR_W(12), .MEM_WAIT(2), .IO_WAIT(3)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .data_out(dout[1]),
    .data_oe(oe[1]), .M1_L(M1_L), .MREQ_L(MREQ_L), .IORQ_L(IORQ_L), .RD_L(RD_L),
    .WR_L(WR_L), .RFSH_L(RFSH_L), .WAIT_L(waitl[1]), .io_rd_data(io_rd_data),
    .io_wr(iowr[1]), .io_rd(iord[1]), .io_addr(ioaddr[1]), .io_wdata(iowdata[1]),
    .int_vector(int_vector), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .bus_err(err[1])
  );

  typedef struct packed {
    int         waits;
    int         lat;
    logic       rd;
    logic [7:0] data;
    int         nwr;
    int         nrd;
    logic [7:0] ioaddr;
    logic [7:0] iowdata;
    logic       err;
    logic       chk_idle;
  } exp_t;

  exp_t sbq[$];

  // Reference state per instance
  logic [7:0] mem_m [2][4096];
  logic [7:0] ioaddr_m [2];
  logic [7:0] iowdata_m [2];
  logic       err_m [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int d, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, got, want);
    end
  endtask

  logic rst_s = 1'b0;
  always @(posedge clk) rst_s <= rst;

  // Monitor
  int         t_c;
  bit         in_cyc = 1'b0;
  bit         idle_pend = 1'b0;
  bit         idle_chk [2];
  bit         prev_oe [2];
  int         waits_c [2];
  int         rises_c [2];
  int         lat_c [2];
  logic [7:0] held_c [2];
  int         nwr_c [2];
  int         nrd_c [2];
  int         frz_c [2];

  initial begin
    exp_t e;
    bit   act;
    for (int d = 0; d < 2; d++) begin
      prev_oe[d]  = 1'b0;
      idle_chk[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      act = !(MREQ_L && IORQ_L && RD_L && WR_L);
      if (rst_s) begin
        for (int d = 0; d < 2; d++) begin
          chk("reset_outputs", d,
              32'({dout[d], oe[d], waitl[d], iowr[d], iord[d], ioaddr[d], iowdata[d], err[d]}),
              32'({8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}));
        end
      end
      if (idle_pend) begin
        idle_pend = 1'b0;
        for (int d = 0; d < 2; d++) begin
          if (idle_chk[d]) chk("idle_oe_wait", d, 32'({oe[d], waitl[d]}), 32'h1);
        end
      end
      if (act || in_cyc) begin
        if (!in_cyc) begin
          in_cyc = 1'b1;
          t_c = 0;
          for (int d = 0; d < 2; d++) begin
            waits_c[d] = 0; rises_c[d] = 0; lat_c[d] = -1; held_c[d] = 8'h00;
            nwr_c[d] = 0; nrd_c[d] = 0; frz_c[d] = 0;
          end
        end else begin
          t_c++;
        end
        for (int d = 0; d < 2; d++) begin
          if (waitl[d] === 1'b0) waits_c[d]++;
          if (oe[d] === 1'b1 && !prev_oe[d]) begin
            rises_c[d]++;
            lat_c[d]  = t_c;
            held_c[d] = dout[d];
          end else if (oe[d] === 1'b1 && dout[d] !== held_c[d]) begin
            frz_c[d]++;
          end
          if (iowr[d] === 1'b1) nwr_c[d]++;
          if (iord[d] === 1'b1) nrd_c[d]++;
        end
        if (!act) begin
          in_cyc = 1'b0;
          for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (sbq.size() == 0) begin
              n_bad++;
              $display("FAIL sb_underflow dut%0d: got 0 entries expected 1", d);
            end else begin
              e = sbq.pop_front();
              chk("wait_cycles", d, 32'(waits_c[d]), 32'(e.waits));
              chk("oe_rises", d, 32'(rises_c[d]), e.rd ? 32'd1 : 32'd0);
              if (e.rd) begin
                chk("read_data", d, 32'(held_c[d]), 32'(e.data));
                chk("read_latency", d, 32'(lat_c[d]), 32'(e.lat));
              end
              chk("io_wr_pulses", d, 32'(nwr_c[d]), 32'(e.nwr));
              chk("io_rd_pulses", d, 32'(nrd_c[d]), 32'(e.nrd));
              chk("io_addr", d, 32'(ioaddr[d]), 32'(e.ioaddr));
              chk("io_wdata", d, 32'(iowdata[d]), 32'(e.iowdata));
              chk("bus_err", d, 32'(err[d]), 32'(e.err));
              chk("hold_frozen", d, 32'(frz_c[d]), 32'd0);
              idle_chk[d] = e.chk_idle;
            end
          end
          idle_pend = 1'b1;
        end
      end
      for (int d = 0; d < 2; d++) prev_oe[d] = (oe[d] === 1'b1);
    end
  end

  task automatic release_bus();
    M1_L = 1'b1; MREQ_L = 1'b1; IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; RFSH_L = 1'b1;
  endtask

  task automatic load_byte(input logic [11:0] a, input logic [7:0] v);
    @(posedge clk); #2;
    load_en = 1'b1; load_addr = a; load_data = v;
    mem_m[0][a] = v; mem_m[1][a] = v;
    @(posedge clk); #2;
    load_en = 1'b0;
  endtask

  // h: number of rising edges the strobes are seen active. do_rst: reset hits the second edge.
  // do_load: a preload pulse during the cycle, which must be ignored.
  task automatic bus_cycle(input int kind, input logic [15:0] a, input logic [7:0] wd,
                           input int h, input bit do_rst, input bit do_load, input bit m1,
                           input logic [7:0] iod, input logic [7:0] vec);
    exp_t e;
    int   n;
    bit   commit;
    bit   ill_io;
    ill_io = 1'($urandom_range(0, 1));
    for (int d = 0; d < 2; d++) begin
      e = '0;
      n = (kind == KMrd || kind == KMwr) ? memw(d) : iow(d);
      if (kind == KRfsh || kind == KIll) begin
        if (kind == KIll) err_m[d] = 1'b1;
        e.chk_idle = 1'b1;
      end else if (do_rst) begin
        e.waits      = (n < 1) ? n : 1;
        err_m[d]     = 1'b0;
        ioaddr_m[d]  = 8'h00;
        iowdata_m[d] = 8'h00;
        e.chk_idle   = 1'b1;
      end else begin
        commit      = (h >= n + 1);
        e.waits     = (n < h) ? n : h;
        e.lat       = n + 1;
        ioaddr_m[d] = a[7:0];
        if (commit) begin
          case (kind)
            KMrd:    begin e.rd = 1'b1; e.data = mem_m[d][a[11:0]]; end
            KMwr:    mem_m[d][a[11:0]] = wd;
            KIord:   begin e.rd = 1'b1; e.data = iod; e.nrd = 1; end
            KIowr:   begin e.nwr = 1; iowdata_m[d] = wd; end
            default: begin e.rd = 1'b1; e.data = vec; end
          endcase
        end
        e.chk_idle = !commit || (h >= n + 2);
      end
      e.ioaddr  = ioaddr_m[d];
      e.iowdata = iowdata_m[d];
      e.err     = err_m[d];
      sbq.push_back(e);
    end

    @(posedge clk); #2;
    addr = a; data_in = wd; io_rd_data = iod; int_vector = vec;
    case (kind)
      KMrd:    begin MREQ_L = 1'b0; RD_L = 1'b0; M1_L = !m1; end
      KMwr:    begin MREQ_L = 1'b0; WR_L = 1'b0; end
      KIord:   begin IORQ_L = 1'b0; RD_L = 1'b0; end
      KIowr:   begin IORQ_L = 1'b0; WR_L = 1'b0; end
      KInta:   begin IORQ_L = 1'b0; M1_L = 1'b0; end
      KRfsh:   begin MREQ_L = 1'b0; RFSH_L = 1'b0; end
      default: begin
        MREQ_L = 1'b0; RD_L = 1'b0;
        if (ill_io) IORQ_L = 1'b0;
        else WR_L = 1'b0;
      end
    endcase
    if (do_rst) begin
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
    end else begin
      for (int i = 1; i <= h; i++) begin
        @(posedge clk); #2;
        if (i == 1 && do_load) begin
          load_en   = 1'b1;
          load_addr = 12'($urandom_range(0, 63));
          load_data = 8'($urandom);
        end else begin
          load_en = 1'b0;
        end
      end
    end
    load_en = 1'b0;
    release_bus();
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         kind;
    int         h;
    bit         r;
    bit         ld;
    logic [15:0] a;
    rst = 1'b1;
    addr = 16'h0000; data_in = 8'h00; io_rd_data = 8'h00; int_vector = 8'h00;
    load_en = 1'b0; load_addr = 12'h000; load_data = 8'h00;
    release_bus();
    for (int d = 0; d < 2; d++) begin
      ioaddr_m[d] = 8'h00; iowdata_m[d] = 8'h00; err_m[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Fill the whole RAM so every later read has a known value.
    for (int i = 0; i < 4096; i++) begin
      @(posedge clk); #2;
      load_en = 1'b1; load_addr = 12'(i); load_data = 8'($urandom);
      mem_m[0][i] = load_data; mem_m[1][i] = load_data;
    end
    @(posedge clk); #2;
    load_en = 1'b0;

    // Opcode fetch from a preloaded byte.
    load_byte(12'h004, 8'h3E);
    bus_cycle(KMrd, 16'h0004, 8'h00, 5, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    // Write then read back through the alias.
    bus_cycle(KMwr, 16'h1123, 8'hA5, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_cycle(KMrd, 16'h0123, 8'h00, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // I/O write held five edges, I/O read, interrupt acknowledge, refresh.
    bus_cycle(KIowr, 16'h347F, 8'h55, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_cycle(KIord, 16'h0042, 8'h00, 6, 1'b0, 1'b0, 1'b0, 8'hC3, 8'h00);
    bus_cycle(KInta, 16'h0000, 8'h00, 6, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);
    bus_cycle(KRfsh, 16'h0010, 8'h00, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Illegal strobes leave RAM alone and latch bus_err.
    bus_cycle(KIll, 16'h0020, 8'h99, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_cycle(KMrd, 16'h0020, 8'h00, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Reset during a write wait: old byte survives, bus_err clears.
    bus_cycle(KMwr, 16'h0010, 8'h11, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_cycle(KMwr, 16'h0010, 8'h22, 2, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_cycle(KMrd, 16'h0010, 8'h00, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Short strobes: abort in the wait-state instance, commit in the zero-wait one.
    bus_cycle(KMwr, 16'h0030, 8'h77, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_cycle(KMrd, 16'h0030, 8'h00, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    bus_cycle(KIowr, 16'h0011, 8'h66, 1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Preload attempt while busy is dropped.
    bus_cycle(KMrd, 16'h0005, 8'h00, 6, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 6);
      h    = ($urandom_range(0, 5) == 0) ? 1 : 5 + $urandom_range(0, 2);
      r    = (kind == KMwr) && ($urandom_range(0, 9) == 0);
      ld   = (h >= 5) && (kind <= KInta) && ($urandom_range(0, 3) == 0);
      a    = {4'($urandom), 6'h00, 6'($urandom)};
      bus_cycle(kind, a, 8'($urandom), h, r, ld, 1'($urandom), 8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 64; i++) begin
      bus_cycle(KMrd, 16'(i), 8'h00, 5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 0, 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
